// File: rtl/ex_hazard_ctrl.sv
// ============================================================================
// Module   : ex_hazard_ctrl
// Purpose  : Execute-stage forwarding, load-use and MULT/DIV stall control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_hazard_ctrl #(
    parameter int MD_CYCLES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IfId_Rs,
    input  logic [4:0]       IfId_Rt,
    input  logic [4:0]       IdEx_Rs,
    input  logic [4:0]       IdEx_Rt,
    input  logic             IdEx_MemRead,
    input  logic             IdEx_MdStart,
    input  logic             ExMem_RegWrite,
    input  logic [4:0]       ExMem_Rd,
    input  logic             MemWb_RegWrite,
    input  logic [4:0]       MemWb_Rd,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             Stall,
    output logic             Bubble,
    output logic             MdBusy,
    output logic             MdDone,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MD_BUSY  = 2'd2
    } state_t;

    localparam logic [7:0] c_MD_LOAD = 8'(MD_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_md_cnt;
    logic [7:0]       w_md_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu;
    logic             w_exmem_hit_a;
    logic             w_exmem_hit_b;
    logic             w_memwb_hit_a;
    logic             w_memwb_hit_b;

    // Forwarding: the younger (EX/MEM) producer wins; r0 is never forwarded.
    always_comb begin
        w_exmem_hit_a = ExMem_RegWrite && (ExMem_Rd != 5'd0) && (ExMem_Rd == IdEx_Rs);
        w_exmem_hit_b = ExMem_RegWrite && (ExMem_Rd != 5'd0) && (ExMem_Rd == IdEx_Rt);
        w_memwb_hit_a = MemWb_RegWrite && (MemWb_Rd != 5'd0) && (MemWb_Rd == IdEx_Rs);
        w_memwb_hit_b = MemWb_RegWrite && (MemWb_Rd != 5'd0) && (MemWb_Rd == IdEx_Rt);

        FwdA = 2'b00;
        if (w_exmem_hit_a)      FwdA = 2'b10;
        else if (w_memwb_hit_a) FwdA = 2'b01;

        FwdB = 2'b00;
        if (w_exmem_hit_b)      FwdB = 2'b10;
        else if (w_memwb_hit_b) FwdB = 2'b01;
    end

    assign w_lu = IdEx_MemRead && (IdEx_Rt != 5'd0) &&
                  ((IdEx_Rt == IfId_Rs) || (IdEx_Rt == IfId_Rt));

    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        Stall         = 1'b0;
        Bubble        = 1'b0;
        MdBusy        = 1'b0;
        MdDone        = 1'b0;

        case (r_state)
            S_RUN: begin
                if (IdEx_MdStart) begin
                    Stall         = 1'b1;
                    Bubble        = 1'b1;
                    MdBusy        = 1'b1;
                    w_md_cnt_next = c_MD_LOAD;
                    w_state_next  = S_MD_BUSY;
                end else if (w_lu) begin
                    Stall        = 1'b1;
                    Bubble       = 1'b1;
                    w_state_next = S_LU_STALL;
                end
            end
            // The load has moved on; ignoring LU here bounds the stall to one cycle.
            S_LU_STALL: begin
                if (IdEx_MdStart) begin
                    Stall         = 1'b1;
                    Bubble        = 1'b1;
                    MdBusy        = 1'b1;
                    w_md_cnt_next = c_MD_LOAD;
                    w_state_next  = S_MD_BUSY;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_MD_BUSY: begin
                Stall         = 1'b1;
                Bubble        = 1'b1;
                MdBusy        = 1'b1;
                w_md_cnt_next = r_md_cnt - 8'd1;
                if (r_md_cnt == 8'd1) begin
                    MdDone       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_md_cnt    <= 8'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
            if (Stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign StallCnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Purpose  : Scoreboard bench for ex_hazard_ctrl with directed and random stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_hazard_ctrl;

    localparam int MD_CYCLES = 8;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       IfId_Rs, IfId_Rt, IdEx_Rs, IdEx_Rt, ExMem_Rd, MemWb_Rd;
    logic             IdEx_MemRead, IdEx_MdStart, ExMem_RegWrite, MemWb_RegWrite;
    logic [1:0]       FwdA, FwdB;
    logic             Stall, Bubble, MdBusy, MdDone;
    logic [CNT_W-1:0] StallCnt;

    ex_hazard_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
        .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_MdStart(IdEx_MdStart),
        .ExMem_RegWrite(ExMem_RegWrite), .ExMem_Rd(ExMem_Rd),
        .MemWb_RegWrite(MemWb_RegWrite), .MemWb_Rd(MemWb_Rd),
        .FwdA(FwdA), .FwdB(FwdB), .Stall(Stall), .Bubble(Bubble),
        .MdBusy(MdBusy), .MdDone(MdDone), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fwda;
        logic [1:0] fwdb;
        logic       stall;
        logic       bubble;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model state: busy cycles left after the start cycle, whether
    // the previous cycle was a load-use stall, and the stall tally.
    int md_left = 0;
    bit lu_prev = 0;
    int cnt     = 0;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (ExMem_RegWrite && ExMem_Rd != 0 && ExMem_Rd == src) return 2'b10;
        if (MemWb_RegWrite && MemWb_Rd != 0 && MemWb_Rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one cycle of inputs, predict the outputs, advance the model.
    task automatic step(input bit rst, input bit mdstart, input bit memrd,
                        input logic [4:0] ifrs, input logic [4:0] ifrt,
                        input logic [4:0] exrs, input logic [4:0] exrt,
                        input bit emw, input logic [4:0] emrd,
                        input bit mww, input logic [4:0] mwrd);
        exp_t e;
        bit   lu;
        int   n_md;
        bit   n_lu;
        reset = rst; IdEx_MdStart = mdstart; IdEx_MemRead = memrd;
        IfId_Rs = ifrs; IfId_Rt = ifrt; IdEx_Rs = exrs; IdEx_Rt = exrt;
        ExMem_RegWrite = emw; ExMem_Rd = emrd; MemWb_RegWrite = mww; MemWb_Rd = mwrd;

        lu = memrd && exrt != 0 && (exrt == ifrs || exrt == ifrt);
        e  = '0;
        e.fwda = fwd_sel(exrs);
        e.fwdb = fwd_sel(exrt);
        e.cnt  = 4'(cnt);
        n_md = 0;
        n_lu = 0;
        if (md_left > 0) begin
            e.stall = 1; e.bubble = 1; e.busy = 1;
            e.done  = (md_left == 1);
            n_md    = md_left - 1;
        end else if (mdstart) begin
            e.stall = 1; e.bubble = 1; e.busy = 1;
            n_md    = MD_CYCLES - 1;
        end else if (lu && !lu_prev) begin
            e.stall = 1; e.bubble = 1;
            n_lu    = 1;
        end
        exp_q.push_back(e);

        if (rst) begin
            md_left = 0; lu_prev = 0; cnt = 0;
        end else begin
            md_left = n_md; lu_prev = n_lu;
            if (e.stall && cnt < CNT_MAX) cnt = cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents a fresh output vector every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a = {FwdA, FwdB, Stall, Bubble, MdBusy, MdDone, StallCnt};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle%0d outputs{FwdA,FwdB,Stall,Bubble,MdBusy,MdDone,StallCnt}: got %b required %b",
                         cyc, a, e);
            end
            cyc++;
        end
    end

    initial begin
        reset = 1; IdEx_MdStart = 0; IdEx_MemRead = 0;
        IfId_Rs = 0; IfId_Rt = 0; IdEx_Rs = 0; IdEx_Rt = 0;
        ExMem_RegWrite = 0; ExMem_Rd = 0; MemWb_RegWrite = 0; MemWb_Rd = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state, then forwarding priority.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 5, 5, 1, 5, 1, 5);
        step(0, 0, 0, 0, 0, 5, 5, 0, 5, 1, 5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);

        // Load-use held for three cycles.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8, 2, 8, 0, 0, 0, 0);
        idle(1);

        // Single MULT/DIV.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 2, 3, 4, 0, 0, 0, 0);
        idle(10);

        // MULT/DIV coinciding with a load-use condition.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 8, 2, 8, 0, 0, 0, 0);
        idle(10);

        // Reset for two cycles during MD_BUSY.
        step(0, 1, 0, 1, 2, 3, 4, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2, 3, 4, 0, 0, 0, 0);
        idle(10);

        // Back-to-back MULT/DIV: 20+ consecutive stall cycles saturate the tally.
        for (int i = 0; i < 22; i++) step(0, 1, 0, 1, 2, 3, 4, 0, 0, 0, 0);
        idle(10);

        // Randomized traffic on a small register window to provoke hits.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 40),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
